// File: rtl/pwm_clock_gen_if.sv
`default_nettype none
// ============================================================================
// pwm_clock_gen_if : control/status bundle for pwm_clock_gen (sync present
//                    only when CLKGEN_SYNC_EN is defined)
// Revision : 1.0
// ============================================================================
interface pwm_clock_gen_if #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 16
);
  logic                    enable;
  logic [NUM_CH-1:0]       load;
  logic [NUM_CH*CNT_W-1:0] period;
  logic [NUM_CH*CNT_W-1:0] high_time;
`ifdef CLKGEN_SYNC_EN
  logic                    sync;
`endif
  logic [NUM_CH-1:0]       clk_out;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       pending;

  modport master (
    output enable, load, period, high_time,
`ifdef CLKGEN_SYNC_EN
    output sync,
`endif
    input  clk_out, tick, pending
  );

  modport slave (
    input  enable, load, period, high_time,
`ifdef CLKGEN_SYNC_EN
    input  sync,
`endif
    output clk_out, tick, pending
  );
endinterface
`default_nettype wire

// File: rtl/pwm_clock_gen.sv
`default_nettype none
// ============================================================================
// pwm_clock_gen : multi-channel divided clock / tick generator with
//                 double-buffered config; CLKGEN_SYNC_EN adds global restart
// Revision : 1.0
// ============================================================================
module pwm_clock_gen #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 16
) (
  input  wire logic      clock,
  input  wire logic      reset,
  pwm_clock_gen_if.slave bus
);

  logic w_sync;

`ifdef CLKGEN_SYNC_EN
  assign w_sync = bus.enable & bus.sync;
`else
  assign w_sync = 1'b0;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] r_per_q;
    logic [CNT_W-1:0] r_hi_q;
    logic [CNT_W-1:0] r_per_s;
    logic [CNT_W-1:0] r_hi_s;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pending;
    logic             r_clk_out;
    logic             r_tick;
    logic             w_stopped;
    logic             w_wrap;
    logic             w_restart;
    logic             w_apply;

    assign w_stopped = (r_per_q == '0);
    assign w_wrap    = (r_cnt == r_per_q - CNT_W'(1));
    assign w_restart = w_stopped | w_wrap | w_sync;
    // Shadow config only moves to the active regs on a period boundary.
    assign w_apply   = bus.enable & r_pending & w_restart;

    always_ff @(posedge clock) begin
      if (reset) begin
        r_per_q   <= '0;
        r_hi_q    <= '0;
        r_per_s   <= '0;
        r_hi_s    <= '0;
        r_cnt     <= '0;
        r_pending <= 1'b0;
        r_clk_out <= 1'b0;
        r_tick    <= 1'b0;
      end else begin
        if (bus.load[i]) begin
          r_per_s <= bus.period[i*CNT_W +: CNT_W];
          r_hi_s  <= bus.high_time[i*CNT_W +: CNT_W];
        end

        if (bus.load[i]) begin
          r_pending <= 1'b1;
        end else if (w_apply) begin
          r_pending <= 1'b0;
        end

        if (bus.enable) begin
          r_tick    <= ~w_stopped & (r_cnt == '0);
          r_clk_out <= ~w_stopped & (r_cnt < r_hi_q);
          if (w_apply) begin
            r_per_q <= r_per_s;
            r_hi_q  <= r_hi_s;
            r_cnt   <= '0;
          end else if (w_restart) begin
            r_cnt   <= '0;
          end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
          end
        end else begin
          r_tick <= 1'b0;
        end
      end
    end

    assign bus.clk_out[i] = r_clk_out;
    assign bus.tick[i]    = r_tick;
    assign bus.pending[i] = r_pending;
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_clock_gen.sv
`default_nettype none
// ============================================================================
// tb_pwm_clock_gen : scoreboard bench with phase-based reference model
// Revision : 1.0
// ============================================================================
module tb_pwm_clock_gen;
  localparam int NCH = 3;
  localparam int CW  = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pwm_clock_gen_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();

  pwm_clock_gen #(.NUM_CH(NCH), .CNT_W(CW)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [3*NCH-1:0] exp_q[$];
  logic [NCH-1:0]   h_clk[$];
  logic [NCH-1:0]   h_tick[$];
  logic [NCH-1:0]   h_pend[$];

  int d_per[NCH];
  int d_hi[NCH];

  int m_per[NCH];
  int m_hi[NCH];
  int m_sper[NCH];
  int m_shi[NCH];
  int m_ph[NCH];
  bit m_pend[NCH];
  bit m_clk[NCH];
  bit m_tick[NCH];

  // Model tracks phase within the current period rather than a counter.
  function automatic void model_edge(bit rs, bit en, bit sy, logic [NCH-1:0] ld);
    bit run, boundary, apply;
    for (int c = 0; c < NCH; c++) begin
      if (rs) begin
        m_per[c] = 0; m_hi[c] = 0; m_sper[c] = 0; m_shi[c] = 0;
        m_ph[c] = 0; m_pend[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
        continue;
      end
      run   = (m_per[c] != 0);
      apply = 1'b0;
      if (en) begin
        m_clk[c]  = run && (m_ph[c] < m_hi[c]);
        m_tick[c] = run && (m_ph[c] == 0);
        boundary  = !run || (m_ph[c] == m_per[c] - 1) || sy;
        apply     = m_pend[c] && boundary;
        if (apply) begin
          m_per[c] = m_sper[c];
          m_hi[c]  = m_shi[c];
          m_ph[c]  = 0;
        end else if (run && !sy) begin
          m_ph[c] = (m_ph[c] + 1) % m_per[c];
        end else begin
          m_ph[c] = 0;
        end
      end else begin
        m_tick[c] = 1'b0;
      end
      if (ld[c]) begin
        m_sper[c] = d_per[c];
        m_shi[c]  = d_hi[c];
        m_pend[c] = 1'b1;
      end else if (apply) begin
        m_pend[c] = 1'b0;
      end
    end
  endfunction

  function automatic logic [3*NCH-1:0] model_out();
    logic [NCH-1:0] c, t, p;
    for (int i = 0; i < NCH; i++) begin
      c[i] = m_clk[i];
      t[i] = m_tick[i];
      p[i] = m_pend[i];
    end
    return {c, t, p};
  endfunction

  task automatic step(input bit rs, input bit en, input bit sy, input logic [NCH-1:0] ld);
    @(negedge clk);
    h_clk.push_back(bus.clk_out);
    h_tick.push_back(bus.tick);
    h_pend.push_back(bus.pending);
    rst        = rs;
    bus.enable = en;
    bus.load   = ld;
    for (int c = 0; c < NCH; c++) begin
      bus.period[c*CW +: CW]    = CW'(d_per[c]);
      bus.high_time[c*CW +: CW] = CW'(d_hi[c]);
    end
`ifdef CLKGEN_SYNC_EN
    bus.sync = sy;
`endif
    model_edge(rs, en, sy, ld);
    exp_q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b1, 1'b0, '0);
  endtask

  task automatic load_ch(input int ch, input int p, input int h);
    d_per[ch] = p;
    d_hi[ch]  = h;
    step(1'b0, 1'b1, 1'b0, NCH'(1) << ch);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  logic [3*NCH-1:0] mon_e, mon_g;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        mon_g = {bus.clk_out, bus.tick, bus.pending};
        vectors++;
        if (mon_g !== mon_e) begin
          miscompares++;
          $display("FAIL scoreboard t=%0t got clk=%b tick=%b pend=%b expected clk=%b tick=%b pend=%b",
                   $time, mon_g[3*NCH-1:2*NCH], mon_g[2*NCH-1:NCH], mon_g[NCH-1:0],
                   mon_e[3*NCH-1:2*NCH], mon_e[2*NCH-1:NCH], mon_e[NCH-1:0]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    logic [7:0] pc, pt;
    bit rs, en, sy;
    logic [NCH-1:0] ld;

    rst = 1'b1; bus.enable = 1'b0; bus.load = '0; bus.period = '0; bus.high_time = '0;
`ifdef CLKGEN_SYNC_EN
    bus.sync = 1'b0;
`endif
    for (int c = 0; c < NCH; c++) begin d_per[c] = 0; d_hi[c] = 0; end

    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, '0);
    idle(1);
    check("reset_state", {h_clk[$], h_tick[$], h_pend[$]}, 0);

    // ch0 P=4 H=2: pending one cycle, then 1100 pattern with tick on rising edge
    load_ch(0, 4, 2);
    idx = h_clk.size();
    idle(11);
    check("ch0_pending_set", h_pend[idx][0], 1);
    check("ch0_pending_clr", h_pend[idx+1][0], 0);
    for (int j = 0; j < 8; j++) begin
      pc[7-j] = h_clk[idx+2+j][0];
      pt[7-j] = h_tick[idx+2+j][0];
    end
    check("ch0_clk_pattern", pc, 8'b1100_1100);
    check("ch0_tick_pattern", pt, 8'b1000_1000);

    load_ch(1, 10, 3);
    idle(6);
    load_ch(1, 5, 1);
    idle(25);

    load_ch(2, 5, 0);
    idle(12);
    load_ch(2, 3, 7);
    idle(10);
    load_ch(2, 1, 1);
    idx = h_clk.size();
    idle(8);
    for (int j = 0; j < 4; j++) begin
      pc[j]   = h_clk[idx+4+j][2];
      pc[j+4] = h_tick[idx+4+j][2];
    end
    check("ch2_p1_every_cycle", pc, 8'hFF);
    load_ch(2, 0, 0);
    idx = h_clk.size();
    idle(8);
    pc = '0;
    for (int j = 0; j < 5; j++) pc[j] = h_clk[idx+3+j][2] | h_tick[idx+3+j][2] | h_pend[idx+3+j][2];
    check("ch2_p0_stopped", pc, 0);

    load_ch(0, 6, 3);
    idle(6);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0, '0);
    idle(14);

    step(1'b1, 1'b0, 1'b0, '0);
    load_ch(1, 8, 4);
    idle(3);
    step(1'b1, 1'b1, 1'b0, '0);
    idx = h_clk.size();
    idle(10);
    check("reset_mid_now", {h_clk[idx][1], h_tick[idx][1], h_pend[idx][1]}, 0);
    check("reset_mid_stays", {h_clk[$], h_tick[$], h_pend[$]}, 0);

`ifdef CLKGEN_SYNC_EN
    load_ch(0, 4, 2);
    idle(1);
    load_ch(1, 6, 3);
    idle(2);
    load_ch(2, 8, 4);
    idle(13);
    step(1'b0, 1'b1, 1'b1, '0);
    idx = h_clk.size();
    idle(3);
    check("sync_ticks_aligned", h_tick[idx+1], 3'b111);
    idle(10);
`endif

    for (int k = 0; k < 400; k++) begin
      rs = ($urandom_range(0, 199) == 0);
      en = ($urandom_range(0, 9) != 0);
`ifdef CLKGEN_SYNC_EN
      sy = ($urandom_range(0, 29) == 0);
`else
      sy = 1'b0;
`endif
      for (int c = 0; c < NCH; c++) begin
        ld[c] = ($urandom_range(0, 7) == 0);
        if (ld[c]) begin
          d_per[c] = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 12));
          d_hi[c]  = int'($urandom_range(0, 14));
        end
      end
      step(rs, en, sy, ld);
    end
    idle(2);

    @(posedge clk);
    #2;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
